// File: rtl/ijtag_access_ctrl_if.sv
// Request/response handshake bundle for the IJTAG access sequencer.
// req_rst exists only when IJTAG_NET_RESET_EN is defined.
interface ijtag_access_ctrl_if #(
    parameter int MAX_LEN = 64,
    parameter int LW      = $clog2(MAX_LEN + 1)
);
    logic               req_valid;
    logic               req_ready;
    logic [LW-1:0]      req_len;
    logic [MAX_LEN-1:0] req_data;
    logic               req_capture;
`ifdef IJTAG_NET_RESET_EN
    logic               req_rst;
`endif
    logic               resp_valid;
    logic               resp_ready;
    logic [MAX_LEN-1:0] resp_data;

    modport master (
`ifdef IJTAG_NET_RESET_EN
        output req_rst,
`endif
        output req_valid, req_len, req_data, req_capture, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
`ifdef IJTAG_NET_RESET_EN
        input  req_rst,
`endif
        input  req_valid, req_len, req_data, req_capture, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/ijtag_access_ctrl.sv
// Host-side IJTAG sequencer: capture / shift / update on the network root.
// Optional network-reset command enabled by macro IJTAG_NET_RESET_EN.
module ijtag_access_ctrl #(
    parameter int MAX_LEN = 64,
    parameter int LW      = $clog2(MAX_LEN + 1)
`ifdef IJTAG_NET_RESET_EN
    , parameter int RST_CYCLES = 4
`endif
) (
    input  logic                ijtag_tck,
    input  logic                ijtag_reset,
    ijtag_access_ctrl_if.slave  bus,
    output logic                ijtag_sel,
    output logic                ijtag_ce,
    output logic                ijtag_se,
    output logic                ijtag_ue,
    output logic                ijtag_si,
    input  logic                ijtag_so,
    output logic                ijtag_to_reset
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, CAPTURE, SHIFT, UPDATE, RESP
`ifdef IJTAG_NET_RESET_EN
        , NRST
`endif
    } state_t;

    state_t             state, state_nx;
    logic [LW-1:0]      len, len_in, cnt, cnt_nx, idx, idx_nx;
    logic [MAX_LEN-1:0] data, sh_src;
    logic               acc, rst_q;

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) state <= IDLE;
        else             state <= state_nx;
    end

    always_comb begin
        len_in   = (bus.req_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.req_len;
        acc      = (state == IDLE) && bus.req_valid && bus.req_ready;
        sh_src   = acc ? bus.req_data : data;
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        case (state)
            IDLE: if (acc) begin
`ifdef IJTAG_NET_RESET_EN
                if (bus.req_rst) begin
                    state_nx = NRST;
                    cnt_nx   = LW'(RST_CYCLES - 1);
                end else
`endif
                if (bus.req_capture) state_nx = CAPTURE;
                else if (len_in == '0) state_nx = UPDATE;
                else begin
                    state_nx = SHIFT;
                    cnt_nx   = len_in - LW'(1);
                    idx_nx   = '0;
                end
            end
            CAPTURE: begin
                if (len == '0) state_nx = UPDATE;
                else begin
                    state_nx = SHIFT;
                    cnt_nx   = len - LW'(1);
                    idx_nx   = '0;
                end
            end
            SHIFT: begin
                idx_nx = idx + LW'(1);
                if (cnt == '0) state_nx = UPDATE;
                else           cnt_nx   = cnt - LW'(1);
            end
            UPDATE: state_nx = RESP;
            RESP: if (bus.resp_valid && bus.resp_ready) state_nx = IDLE;
`ifdef IJTAG_NET_RESET_EN
            NRST: begin
                if (cnt == '0) state_nx = RESP;
                else           cnt_nx   = cnt - LW'(1);
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Controls are registered from the next state so they line up with the
    // state they belong to; resp_valid trails RESP entry by one cycle.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            rst_q          <= 1'b1;
            len            <= '0;
            cnt            <= '0;
            idx            <= '0;
            data           <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            ijtag_sel      <= 1'b0;
            ijtag_ce       <= 1'b0;
            ijtag_se       <= 1'b0;
            ijtag_ue       <= 1'b0;
            ijtag_si       <= 1'b0;
            ijtag_to_reset <= 1'b0;
        end else begin
            rst_q          <= 1'b0;
            cnt            <= cnt_nx;
            idx            <= idx_nx;
            bus.req_ready  <= (state_nx == IDLE);
            bus.resp_valid <= (state == RESP) && !(bus.resp_valid && bus.resp_ready);
            ijtag_sel      <= (state_nx == CAPTURE) || (state_nx == SHIFT) || (state_nx == UPDATE);
            ijtag_ce       <= (state_nx == CAPTURE);
            ijtag_se       <= (state_nx == SHIFT);
            ijtag_ue       <= (state_nx == UPDATE);
            ijtag_si       <= (state_nx == SHIFT) ? sh_src[idx_nx[IW-1:0]] : 1'b0;
`ifdef IJTAG_NET_RESET_EN
            ijtag_to_reset <= !rst_q && (state_nx != NRST);
`else
            ijtag_to_reset <= !rst_q;
`endif
            if (acc) begin
                len           <= len_in;
                data          <= bus.req_data;
                bus.resp_data <= '0;
            end
            if (state == SHIFT) bus.resp_data[idx[IW-1:0]] <= ijtag_so;
        end
    end
endmodule

// File: tb/tb_ijtag_access_ctrl.sv
// Self-checking bench: small SIB/TDR network model plus a cycle-offset
// reference for randomized scans (expected bits taken from the driven so pattern).
module tb_ijtag_access_ctrl;
    localparam int ML = 64;
    localparam int LW = $clog2(ML + 1);

    logic clk = 1'b0, rst = 1'b1;
    logic sel, ce, se, ue, si, so, to_reset;
    int   checks = 0, errors = 0;
    int   cyc = 0, acc_cyc = 1000000;
    int   mode = 0;
    logic [127:0] pattern = '0;
    logic pat_so = 1'b0, so_net = 1'b0;
    logic [8:0] tdr = '0;
    logic sib_sh = 1'b0, sib_open = 1'b0;

    ijtag_access_ctrl_if #(.MAX_LEN(ML)) bus ();

    ijtag_access_ctrl #(.MAX_LEN(ML)
`ifdef IJTAG_NET_RESET_EN
        , .RST_CYCLES(4)
`endif
    ) dut (
        .ijtag_tck(clk), .ijtag_reset(rst), .bus(bus),
        .ijtag_sel(sel), .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue),
        .ijtag_si(si), .ijtag_so(so), .ijtag_to_reset(to_reset)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Network: mode 0 = lone 9-bit TDR, mode 1 = SIB gating the TDR, mode 2 = pattern
    always @(posedge clk) begin
        if (sel && ce) begin
            tdr    <= 9'h0F3;
            sib_sh <= sib_open;
        end else if (sel && se) begin
            if (mode == 0 || sib_open) tdr <= {si, tdr[8:1]};
            if (mode == 1) sib_sh <= sib_open ? tdr[0] : si;
        end
    end
    always @(negedge clk) begin
        if (mode == 1 && sel && ue) sib_open <= sib_sh;
        so_net <= (mode == 1) ? sib_sh : tdr[0];
        if (cyc - acc_cyc >= 0 && cyc - acc_cyc < 128) pat_so <= pattern[cyc - acc_cyc];
        else pat_so <= 1'b0;
    end
    assign so = (mode == 2) ? pat_so : so_net;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input int rlen, input bit cap, input logic [ML-1:0] d, input bit nrst);
        int n;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_len     = LW'(rlen);
        bus.req_data    = d;
        bus.req_capture = cap;
`ifdef IJTAG_NET_RESET_EN
        bus.req_rst     = nrst;
`endif
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_len   = LW'($urandom);
        bus.req_data  = {$urandom, $urandom};
`ifdef IJTAG_NET_RESET_EN
        bus.req_rst   = 1'b0;
`endif
    endtask

    task automatic finish_resp(input int hold, input logic [ML-1:0] exp);
        int drops = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_data !== exp) drops++;
        end
        check("resp_hold", 64'(drops), 64'd0);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check("resp_drop", 64'({bus.resp_valid, bus.req_ready}), 64'b01);
    endtask

    // use_pat: expected bits come from the so pattern at offsets cap+k
    task automatic run_req(input int rlen, input bit cap, input logic [ML-1:0] d,
                           input logic [ML-1:0] exp_in, input bit use_pat, input int hold);
        int len, ce_n, se_n, ue_n, bad, lat;
        logic [ML-1:0] exp, mask, si_seq;
        len = (rlen > ML) ? ML : rlen;
        pattern = {$urandom, $urandom, $urandom, $urandom};
        exp = '0; mask = '0; si_seq = '0;
        for (int k = 0; k < len; k++) begin
            mask[k] = 1'b1;
            if (use_pat) exp[k] = pattern[cap + k];
        end
        if (!use_pat) exp = exp_in;
        ce_n = 0; se_n = 0; ue_n = 0; bad = 0; lat = -1;
        accept(rlen, cap, d, 1'b0);
        for (int off = 0; off < 200; off++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = off;
                break;
            end
            if (ce) ce_n++;
            if (se) begin
                if (se_n < ML) si_seq[se_n] = si;
                se_n++;
            end
            if (ue) ue_n++;
            if ((int'(ce) + int'(se) + int'(ue)) > 1 || ((ce || se || ue) && !sel) ||
                (si && !se) || bus.req_ready) bad++;
        end
        check("latency", 64'(lat), 64'(int'(cap) + len + 2));
        check("ce_cycles", 64'(ce_n), 64'(cap));
        check("se_cycles", 64'(se_n), 64'(len));
        check("ue_cycles", 64'(ue_n), 64'd1);
        check("ctrl_excl", 64'(bad), 64'd0);
        check("si_seq", si_seq, d & mask);
        check("resp_data", bus.resp_data, exp);
        finish_resp(hold, exp);
    endtask

    initial begin
        int seen;
        bus.req_valid = 1'b0; bus.req_len = '0; bus.req_data = '0; bus.req_capture = 1'b0;
        bus.resp_ready = 1'b0;
`ifdef IJTAG_NET_RESET_EN
        bus.req_rst = 1'b0;
`endif
        // reset and release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_to_reset", 64'(to_reset), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", 64'(bus.req_ready), 64'd1);
        check("rel_to_reset", 64'(to_reset), 64'd0);
        check("rel_ctrls", 64'({sel, ce, se, ue, si, bus.resp_valid}), 64'd0);
        check("rel_resp_data", bus.resp_data, 64'd0);
        @(negedge clk);
        check("to_reset_high", 64'(to_reset), 64'd1);

        // captured 9-bit TDR
        mode = 0;
        run_req(9, 1'b1, 64'h1A5, 64'h0F3, 1'b0, 1);

        // SIB opens, then SIB bit followed by the sub-TDR
        mode = 1;
        run_req(1, 1'b0, 64'h1, 64'h0, 1'b0, 0);
        check("sib_open", 64'(sib_open), 64'd1);
        run_req(10, 1'b1, 64'h2AB, 64'h1E7, 1'b0, 2);

        // length boundaries
        mode = 2;
        run_req(ML + 5, 1'b0, {$urandom, $urandom}, '0, 1'b1, 0);
        run_req(ML, 1'b1, {$urandom, $urandom}, '0, 1'b1, 0);
        run_req(0, 1'b1, {$urandom, $urandom}, '0, 1'b1, 1);
        run_req(0, 1'b0, {$urandom, $urandom}, '0, 1'b1, 0);

        for (int t = 0; t < 16; t++)
            run_req($urandom_range(0, ML + 3), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    '0, 1'b1, $urandom_range(0, 3));

        // reset in the 4th shift cycle
        accept(20, 1'b0, {$urandom, $urandom}, 1'b0);
        repeat (4) @(negedge clk);
        check("mid_se_before", 64'(se), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_ctrls_drop", 64'({sel, se, bus.req_ready}), 64'd0);
        rst = 1'b0;
        seen = 0;
        @(negedge clk);
        check("mid_ready_back", 64'(bus.req_ready), 64'd1);
        repeat (25) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("mid_no_resp", 64'(seen), 64'd0);
        run_req(5, 1'b1, {$urandom, $urandom}, '0, 1'b1, 0);

`ifdef IJTAG_NET_RESET_EN
        begin
            int low_n = 0, sel_n = 0, lat = -1;
            accept(7, 1'b1, {$urandom, $urandom}, 1'b1);
            for (int off = 0; off < 40; off++) begin
                @(negedge clk);
                if (bus.resp_valid) begin
                    lat = off;
                    break;
                end
                if (!to_reset) low_n++;
                if (sel) sel_n++;
            end
            check("nrst_low_cycles", 64'(low_n), 64'd4);
            check("nrst_sel", 64'(sel_n), 64'd0);
            check("nrst_resp", 64'(lat >= 0), 64'd1);
            check("nrst_data", bus.resp_data, 64'd0);
            finish_resp(3, 64'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ijtag_access_ctrl.md
# ijtag_access_ctrl

Host-side sequencer that drives an IJTAG scan network of SIBs and TDRs from its root. It accepts one scan request at a time over a valid/ready handshake and runs capture, shift and update on the network control signals. The bits shifted out are returned as a response. It is the stage directly upstream of the top-level reset TDR and SIB chain, and it owns the network's active-low reset line.

## Interface
Parameters:
- MAX_LEN, 64, maximum scan length in bits (≥2)
- LW, $clog2(MAX_LEN+1), width of length fields
- RST_CYCLES, 4, network-reset pulse width in ijtag_tck cycles (macro only)

Ports:
- ijtag_tck  in  1  single clock; all state on posedge
- ijtag_reset  in  1  synchronous, active-high block reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_len  in  LW  bits to shift; clamped to MAX_LEN
- req_data  in  MAX_LEN  shift-in data, bit 0 shifted first
- req_capture  in  1  1 = issue capture cycle before shift
- req_rst  in  1  network-reset command (only with IJTAG_NET_RESET_EN)
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  response accepted
- resp_data  out  MAX_LEN  shifted-out bits; bit i = i-th sampled ijtag_so; bits ≥ len are 0
- ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue  out  1 each  network control
- ijtag_si  out  1  network scan-in
- ijtag_so  in  1  network scan-out (negedge-retimed by the network)
- ijtag_to_reset  out  1  network reset, active-low

## Operation
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP, plus NRST when the macro is set.
- IDLE:
  - req_ready=1.
  - On req_valid, latch len=min(req_len,MAX_LEN), data and capture.
  - Go to CAPTURE if capture=1, otherwise to SHIFT (or UPDATE if len=0).
- CAPTURE: one cycle with sel=1, ce=1. Next state is SHIFT, or UPDATE if len=0.
- SHIFT:
  - Exactly len cycles with sel=1, se=1.
  - ijtag_si = data[k] in shift cycle k (k=0..len-1).
  - ijtag_so is sampled at the posedge that ends cycle k and stored into resp_data[k].
  - A down-counter loaded with len-1; leave to UPDATE when it reaches 0.
- UPDATE: one cycle with sel=1, ue=1. The network latches on the following negedge.
- RESP:
  - resp_valid=1; resp_data stable.
  - On resp_ready, return to IDLE.
- Control outputs are mutually exclusive; at most one of ce/se/ue is high, and only when sel=1.
- ijtag_si=0 whenever se=0.
- A new request is never accepted while resp_valid=1.
- Length arithmetic:
  - Lengths above MAX_LEN are clamped silently.
  - len=0 performs capture (if requested) and update with no shift; resp_data=0.
- Reset mid-operation:
  - Return to IDLE on the next posedge and drop all controls.
  - The in-flight request is discarded and no response is produced.

## Timing
- All outputs are registered.
- Reset values:
  - req_ready=0 while ijtag_reset is high; 1 the cycle after release.
  - resp_valid=0, resp_data=0.
  - sel/ce/se/ue/si=0.
  - ijtag_to_reset=0 while ijtag_reset is high and for one cycle after; then 1.
- Latency from acceptance edge to resp_valid: capture + len + 1 (update) + 1 cycles.
  - Example: len=9 with capture gives 12 cycles.
- Sample alignment: ijtag_so sampled at shift edge k carries the bit that tdr[0] held before that edge. For a captured TDR, resp_data[0] is the captured bit 0.
- Back-to-back requests: at least one IDLE cycle separates the end of RESP from the next CAPTURE or SHIFT.

## Configuration
- Macro: IJTAG_NET_RESET_EN.
- Defined:
  - The req_rst port exists.
  - An IDLE acceptance with req_rst=1 enters NRST: ijtag_to_reset=0 and sel=0 for RST_CYCLES cycles, then RESP with resp_data=0.
  - req_rst takes priority over the other request fields.
- Undefined:
  - No req_rst port and no NRST state.
  - ijtag_to_reset depends only on ijtag_reset.

## Test plan
- Reset for 3 cycles, then release → ijtag_to_reset goes 0→1 one cycle after release; req_ready=1; all controls 0.
- Request len=9, capture=1, data=9'h1A5, against a TDR model holding capture value 9'h0F3 → ce for 1 cycle, se for 9 cycles, si sequence 1,0,1,0,0,1,0,1,1, ue for 1 cycle; resp_data=9'h0F3; resp_valid 12 cycles after acceptance.
- Request len=1, capture=0 on a closed SIB, data bit 1 → SIB opens after update; a second request with len=10 returns the SIB bit followed by 9 sub-TDR bits.
- req_len=MAX_LEN+5 → exactly MAX_LEN se cycles; len=0 with capture=1 → ce then ue, no se, resp_data=0.
- ijtag_reset asserted in the 4th SHIFT cycle → se/sel drop the next cycle; no resp_valid; req_ready returns after release.
- With IJTAG_NET_RESET_EN and RST_CYCLES=4: req_rst=1 → ijtag_to_reset low exactly 4 cycles, sel=0 throughout, then resp_valid=1 with resp_data=0; resp_ready held low for 3 cycles keeps resp_valid high.
